// File: rtl/tdd_channel_monitor.sv
// Checks where a TDD control line turns on and off within each frame against
// expected positions, and keeps the measured positions plus sticky error flags.
module tdd_channel_monitor #(
  parameter int REGISTER_WIDTH = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      enable,
  input  logic                      err_clr,
  input  logic                      frame_start,
  input  logic                      ch_in,
  input  logic                      ch_polarity,
  input  logic [REGISTER_WIDTH-1:0] exp_on,
  input  logic [REGISTER_WIDTH-1:0] exp_off,
  input  logic [REGISTER_WIDTH-1:0] exp_frame_length,
  output logic [REGISTER_WIDTH-1:0] meas_on,
  output logic [REGISTER_WIDTH-1:0] meas_off,
  output logic [REGISTER_WIDTH-1:0] meas_frame_length,
  output logic [31:0]               frame_count,
  output logic                      err_on,
  output logic                      err_off,
  output logic                      err_frame,
  output logic                      frame_done,
  output logic [1:0]                state
);

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    ARMED   = 2'b01,
    RUNNING = 2'b11
  } state_t;

  state_t                    r_state;
  state_t                    w_state_next;
  logic [REGISTER_WIDTH-1:0] r_cnt;
  logic                      r_ch_q;
  logic                      r_on_seen;
  logic                      r_off_seen;
  logic [REGISTER_WIDTH-1:0] r_meas_on;
  logic [REGISTER_WIDTH-1:0] r_meas_off;
  logic [REGISTER_WIDTH-1:0] r_meas_frame_length;
  logic [31:0]               r_frame_count;
  logic                      r_err_on;
  logic                      r_err_off;
  logic                      r_err_frame;
  logic                      r_frame_done;

  logic                      w_ch;
  logic                      w_rise;
  logic                      w_fall;
  logic                      w_cnt_max;
  logic [REGISTER_WIDTH-1:0] w_pos;
  logic                      w_active;
  logic                      w_frame_end;
  logic                      w_arm;
  logic                      w_on_seen_eff;
  logic                      w_off_seen_eff;
  logic                      w_on_hit;
  logic                      w_off_hit;
  logic                      w_set_err_on;
  logic                      w_set_err_off;
  logic                      w_set_err_frame;

  assign w_ch      = ch_in ^ ch_polarity;
  assign w_rise    = w_ch & ~r_ch_q;
  assign w_fall    = ~w_ch & r_ch_q;
  assign w_cnt_max = &r_cnt;
  assign w_pos     = frame_start ? '0
                   : (w_cnt_max ? r_cnt : r_cnt + REGISTER_WIDTH'(1));

  // The arming frame_start opens the first frame, so edges there already count.
  assign w_active    = (r_state == RUNNING) || ((r_state == ARMED) && frame_start);
  assign w_frame_end = (r_state == RUNNING) && frame_start;
  assign w_arm       = (r_state == IDLE) && enable;

  // A frame_start starts a new frame, so the old seen flags no longer apply.
  assign w_on_seen_eff  = frame_start ? 1'b0 : r_on_seen;
  assign w_off_seen_eff = frame_start ? 1'b0 : r_off_seen;
  assign w_on_hit       = w_active & w_rise;
  assign w_off_hit      = w_active & w_fall;

  assign w_set_err_on    = (w_on_hit & (w_on_seen_eff | (w_pos != exp_on)))
                         | (w_frame_end & ~r_on_seen);
  assign w_set_err_off   = (w_off_hit & (w_off_seen_eff | (w_pos != exp_off)))
                         | (w_frame_end & ~r_off_seen);
  assign w_set_err_frame = (w_frame_end & (r_cnt != exp_frame_length))
                         | ((r_state == RUNNING) & ~frame_start & w_cnt_max);

  always_comb begin
    w_state_next = r_state;
    if (!enable) begin
      w_state_next = IDLE;
    end else begin
      case (r_state)
        IDLE:    w_state_next = ARMED;
        ARMED:   if (frame_start) w_state_next = RUNNING;
        RUNNING: w_state_next = RUNNING;
        default: w_state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= IDLE;
      r_cnt        <= '0;
      r_ch_q       <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      r_state      <= w_state_next;
      r_cnt        <= w_active ? w_pos : '0;
      r_ch_q       <= w_ch;
      r_frame_done <= w_frame_end;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_on_seen           <= 1'b0;
      r_off_seen          <= 1'b0;
      r_meas_on           <= '0;
      r_meas_off          <= '0;
      r_meas_frame_length <= '0;
      r_frame_count       <= '0;
    end else begin
      if (w_arm) begin
        r_on_seen     <= 1'b0;
        r_off_seen    <= 1'b0;
        r_frame_count <= '0;
      end else if (w_active) begin
        r_on_seen  <= w_on_seen_eff | w_rise;
        r_off_seen <= w_off_seen_eff | w_fall;
        if (w_frame_end && (r_frame_count != 32'hFFFF_FFFF))
          r_frame_count <= r_frame_count + 32'd1;
      end
      if (w_on_hit && !w_on_seen_eff)
        r_meas_on <= w_pos;
      if (w_off_hit && !w_off_seen_eff)
        r_meas_off <= w_pos;
      if (w_frame_end)
        r_meas_frame_length <= r_cnt;
    end
  end

  // A new error event outranks a simultaneous err_clr.
  always_ff @(posedge clk) begin
    if (rst || w_arm) begin
      r_err_on    <= 1'b0;
      r_err_off   <= 1'b0;
      r_err_frame <= 1'b0;
    end else begin
      r_err_on    <= w_set_err_on    | (r_err_on    & ~err_clr);
      r_err_off   <= w_set_err_off   | (r_err_off   & ~err_clr);
      r_err_frame <= w_set_err_frame | (r_err_frame & ~err_clr);
    end
  end

  assign state             = r_state;
  assign meas_on           = r_meas_on;
  assign meas_off          = r_meas_off;
  assign meas_frame_length = r_meas_frame_length;
  assign frame_count       = r_frame_count;
  assign err_on            = r_err_on;
  assign err_off           = r_err_off;
  assign err_frame         = r_err_frame;
  assign frame_done        = r_frame_done;

endmodule

// File: tb/tb_tdd_channel_monitor.sv
// Directed bench for tdd_channel_monitor; frames are described by on/off/glitch
// positions and every expected value is worked out by hand.
module tb_tdd_channel_monitor;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         enable = 1'b0;
  logic         err_clr = 1'b0;
  logic         frame_start = 1'b0;
  logic         ch_in = 1'b0;
  logic         ch_polarity = 1'b0;
  logic [W-1:0] exp_on = '0;
  logic [W-1:0] exp_off = '0;
  logic [W-1:0] exp_frame_length = '0;
  logic [W-1:0] meas_on;
  logic [W-1:0] meas_off;
  logic [W-1:0] meas_frame_length;
  logic [31:0]  frame_count;
  logic         err_on;
  logic         err_off;
  logic         err_frame;
  logic         frame_done;
  logic [1:0]   state;

  int errors = 0;
  int checks = 0;
  int doneCount = 0;
  int onPos = -1;
  int offPos = -1;
  int glitchPos = -1;
  int clrPos = -1;

  tdd_channel_monitor #(.REGISTER_WIDTH(W)) dut (
    .clk(clk), .rst(rst), .enable(enable), .err_clr(err_clr),
    .frame_start(frame_start), .ch_in(ch_in), .ch_polarity(ch_polarity),
    .exp_on(exp_on), .exp_off(exp_off), .exp_frame_length(exp_frame_length),
    .meas_on(meas_on), .meas_off(meas_off), .meas_frame_length(meas_frame_length),
    .frame_count(frame_count), .err_on(err_on), .err_off(err_off),
    .err_frame(err_frame), .frame_done(frame_done), .state(state)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (frame_done === 1'b1) doneCount++;

  function automatic logic level(input int p);
    return ((p >= onPos) && (p < offPos)) || (p == glitchPos);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drives frame positions pFrom..pTo; position 0 carries frame_start.
  task automatic drive(input int pFrom, input int pTo);
    for (int p = pFrom; p <= pTo; p++) begin
      frame_start = (p == 0);
      err_clr     = (p == clrPos);
      ch_in       = ch_polarity ^ level(p);
      tick();
    end
    frame_start = 1'b0;
    err_clr     = 1'b0;
  endtask

  task automatic arm(input int eOn, input int eOff, input int eLen);
    exp_on = W'(eOn); exp_off = W'(eOff); exp_frame_length = W'(eLen);
    onPos = -1; offPos = -1; glitchPos = -1; clrPos = -1;
    ch_in = ch_polarity;
    frame_start = 1'b0; err_clr = 1'b0;
    rst = 1'b1; enable = 1'b0;
    tick();
    rst = 1'b0; enable = 1'b1;
    tick();
    doneCount = 0;
  endtask

  task automatic test_reset();
    rst = 1'b1; enable = 1'b1;
    tick();
    checks++; if (state !== 2'b00) begin errors++; $display("[TB] FAIL rst_state: got %b want 00", state); end
    checks++; if (frame_count !== 32'd0) begin errors++; $display("[TB] FAIL rst_frame_count: got %0d want 0", frame_count); end
    checks++; if ({meas_on, meas_off, meas_frame_length} !== '0) begin errors++; $display("[TB] FAIL rst_meas: got %0d/%0d/%0d want 0/0/0", meas_on, meas_off, meas_frame_length); end
    checks++; if ({err_on, err_off, err_frame, frame_done} !== 4'b0) begin errors++; $display("[TB] FAIL rst_flags: got %b want 0000", {err_on, err_off, err_frame, frame_done}); end
    rst = 1'b0;
    tick();
    checks++; if (state !== 2'b01) begin errors++; $display("[TB] FAIL rst_arm: got %b want 01", state); end
    enable = 1'b0;
    tick();
    checks++; if (state !== 2'b00) begin errors++; $display("[TB] FAIL rst_disable: got %b want 00", state); end
  endtask

  task automatic test_nominal(input logic pol);
    ch_polarity = pol;
    arm(10, 20, 99);
    onPos = 10; offPos = 20;
    for (int f = 0; f < 3; f++) drive(0, 99);
    drive(0, 0);
    checks++; if (frame_count !== 32'd3) begin errors++; $display("[TB] FAIL nom%0d_frame_count: got %0d want 3", pol, frame_count); end
    checks++; if (meas_on !== W'(10) || meas_off !== W'(20)) begin errors++; $display("[TB] FAIL nom%0d_meas_on_off: got %0d/%0d want 10/20", pol, meas_on, meas_off); end
    checks++; if (meas_frame_length !== W'(99)) begin errors++; $display("[TB] FAIL nom%0d_meas_len: got %0d want 99", pol, meas_frame_length); end
    checks++; if ({err_on, err_off, err_frame} !== 3'b000) begin errors++; $display("[TB] FAIL nom%0d_errors: got %b want 000", pol, {err_on, err_off, err_frame}); end
    checks++; if (frame_done !== 1'b1 || state !== 2'b11) begin errors++; $display("[TB] FAIL nom%0d_done_state: got %b/%b want 1/11", pol, frame_done, state); end
    drive(1, 1);
    checks++; if (frame_done !== 1'b0 || doneCount != 3) begin errors++; $display("[TB] FAIL nom%0d_done_pulses: got %b/%0d want 0/3", pol, frame_done, doneCount); end
    enable = 1'b0;
    tick();
    checks++; if (state !== 2'b00 || frame_count !== 32'd3 || meas_on !== W'(10)) begin errors++; $display("[TB] FAIL nom%0d_hold: got %b/%0d/%0d want 00/3/10", pol, state, frame_count, meas_on); end
    ch_polarity = 1'b0;
  endtask

  task automatic test_misplacement();
    arm(10, 20, 99);
    onPos = 11; offPos = 20;
    drive(0, 11);
    checks++; if (err_on !== 1'b1 || meas_on !== W'(11)) begin errors++; $display("[TB] FAIL mis_detect: got err_on=%b meas_on=%0d want 1/11", err_on, meas_on); end
    clrPos = 12;
    drive(12, 12);
    checks++; if (err_on !== 1'b0 || err_off !== 1'b0) begin errors++; $display("[TB] FAIL mis_clear: got %b/%b want 0/0", err_on, err_off); end
    clrPos = 11;
    drive(13, 99);
    drive(0, 11);
    checks++; if (err_on !== 1'b1 || meas_on !== W'(11)) begin errors++; $display("[TB] FAIL mis_clr_collide: got err_on=%b meas_on=%0d want 1/11", err_on, meas_on); end
    checks++; if (frame_count !== 32'd1 || err_frame !== 1'b0) begin errors++; $display("[TB] FAIL mis_frame: got count=%0d err_frame=%b want 1/0", frame_count, err_frame); end
  endtask

  task automatic test_glitch_missing();
    arm(10, 20, 99);
    onPos = 10; offPos = 20; glitchPos = 50;
    drive(0, 99);
    checks++; if (err_on !== 1'b1 || err_off !== 1'b1) begin errors++; $display("[TB] FAIL glitch_errs: got %b/%b want 1/1", err_on, err_off); end
    checks++; if (meas_on !== W'(10) || meas_off !== W'(20)) begin errors++; $display("[TB] FAIL glitch_meas_held: got %0d/%0d want 10/20", meas_on, meas_off); end
    onPos = -1; offPos = -1; glitchPos = -1; clrPos = 5;
    drive(0, 5);
    checks++; if (err_on !== 1'b0 || err_off !== 1'b0) begin errors++; $display("[TB] FAIL glitch_clear: got %b/%b want 0/0", err_on, err_off); end
    clrPos = -1;
    drive(6, 99);
    drive(0, 0);
    checks++; if (err_on !== 1'b1 || err_off !== 1'b1 || err_frame !== 1'b0) begin errors++; $display("[TB] FAIL missing_edges: got %b/%b/%b want 1/1/0", err_on, err_off, err_frame); end
    checks++; if (frame_count !== 32'd2 || meas_on !== W'(10)) begin errors++; $display("[TB] FAIL missing_count: got %0d/%0d want 2/10", frame_count, meas_on); end
  endtask

  task automatic test_frame_length();
    arm(10, 20, 99);
    onPos = 10; offPos = 20;
    drive(0, 79);
    drive(0, 0);
    checks++; if (err_frame !== 1'b1 || meas_frame_length !== W'(79)) begin errors++; $display("[TB] FAIL len_short: got err=%b len=%0d want 1/79", err_frame, meas_frame_length); end
    checks++; if (err_on !== 1'b0 || err_off !== 1'b0) begin errors++; $display("[TB] FAIL len_edges: got %b/%b want 0/0", err_on, err_off); end
  endtask

  task automatic test_saturation();
    arm(10, 20, 99);
    drive(0, 0);
    drive(1, 255);
    checks++; if (err_frame !== 1'b0) begin errors++; $display("[TB] FAIL sat_early: got %b want 0", err_frame); end
    drive(256, 256);
    checks++; if (err_frame !== 1'b1 || meas_frame_length !== W'(0)) begin errors++; $display("[TB] FAIL sat_overflow: got err=%b len=%0d want 1/0", err_frame, meas_frame_length); end
  endtask

  task automatic test_boundary();
    arm(0, 20, 99);
    onPos = 5; offPos = 20; clrPos = 50;
    drive(0, 99);
    checks++; if (meas_on !== W'(5) || err_on !== 1'b0) begin errors++; $display("[TB] FAIL bnd_setup: got %0d/%b want 5/0", meas_on, err_on); end
    onPos = 0; clrPos = -1;
    drive(0, 0);
    checks++; if (meas_on !== W'(0) || err_on !== 1'b0) begin errors++; $display("[TB] FAIL bnd_rise_at_start: got %0d/%b want 0/0", meas_on, err_on); end
    checks++; if (frame_count !== 32'd1 || meas_frame_length !== W'(99)) begin errors++; $display("[TB] FAIL bnd_count: got %0d/%0d want 1/99", frame_count, meas_frame_length); end
    drive(1, 30);
    checks++; if (meas_off !== W'(20) || err_off !== 1'b0) begin errors++; $display("[TB] FAIL bnd_fall: got %0d/%b want 20/0", meas_off, err_off); end
    rst = 1'b1;
    tick();
    checks++; if (state !== 2'b00 || frame_count !== 32'd0 || frame_done !== 1'b0) begin errors++; $display("[TB] FAIL bnd_rst_state: got %b/%0d/%b want 00/0/0", state, frame_count, frame_done); end
    checks++; if ({meas_on, meas_off, meas_frame_length} !== '0 || {err_on, err_off, err_frame} !== 3'b0) begin errors++; $display("[TB] FAIL bnd_rst_outputs: got %0d/%0d/%0d err=%b want zeros", meas_on, meas_off, meas_frame_length, {err_on, err_off, err_frame}); end
    rst = 1'b0;
    tick();
    onPos = 35; offPos = 38;
    drive(31, 40);
    checks++; if (state !== 2'b01 || meas_on !== W'(0) || meas_off !== W'(0)) begin errors++; $display("[TB] FAIL bnd_rearm_ignore: got %b/%0d/%0d want 01/0/0", state, meas_on, meas_off); end
    checks++; if ({err_on, err_off, err_frame} !== 3'b0 || frame_count !== 32'd0) begin errors++; $display("[TB] FAIL bnd_rearm_errs: got %b/%0d want 000/0", {err_on, err_off, err_frame}, frame_count); end
  endtask

  initial begin
    test_reset();
    test_nominal(1'b0);
    test_misplacement();
    test_glitch_missing();
    test_frame_length();
    test_nominal(1'b1);
    test_saturation();
    test_boundary();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
